// File: rtl/mem_rd_pkg.sv
// Shared types and sizing for mem_stream_reader and its FIFO.
// Optional last-word flag is enabled by defining MEM_RD_LAST_EN.
package mem_rd_pkg;

    localparam int DEF_RAM_DEPTH = 512;
    localparam int DEF_RAM_ADDRW = $clog2(DEF_RAM_DEPTH);
    localparam int DEF_RAM_WIDTH = 32;
    localparam int DEF_LEN_W     = DEF_RAM_ADDRW + 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t;

    // One extra bit so a command can cover the whole RAM.
    function automatic int len_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_rd_fifo2.sv
// Two-entry skid FIFO between RAM read capture and the output stream.
module mem_rd_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic       rd_ptr_reg;
    logic       wr_ptr_reg;
    logic [1:0] count_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [WIDTH-1:0] slot_reg;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    slot_reg <= '0;
                end else if (push_i && (wr_ptr_reg == 1'(gi))) begin
                    slot_reg <= push_data_i;
                end
            end
        end
    endgenerate

    // When full, push and pop target the same slot: the head is read before it is overwritten.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop_i)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push_i, pop_i})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_o  = rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;
    assign count_o = count_reg;

endmodule

// File: rtl/mem_stream_reader.sv
// Walks {base,len} over the weight RAM with wrap-around and streams the words out.
// Define MEM_RD_LAST_EN to add m_last_o marking the final word of each command.
module mem_stream_reader
    import mem_rd_pkg::*;
#(
    parameter int RAM_DEPTH = DEF_RAM_DEPTH,
    parameter int RAM_ADDRW = $clog2(RAM_DEPTH),
    parameter int RAM_WIDTH = DEF_RAM_WIDTH,
    parameter int LEN_W     = RAM_ADDRW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [RAM_ADDRW-1:0] cmd_base_i,
    input  logic [LEN_W-1:0]     cmd_len_i,
    input  logic                 wr_busy_i,
    output logic [RAM_ADDRW-1:0] ram_rd_addr_o,
    input  logic [RAM_WIDTH-1:0] ram_rd_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [RAM_WIDTH-1:0] m_data_o,
    output logic                 busy_o,
`ifdef MEM_RD_LAST_EN
    output logic                 m_last_o,
`endif
    output logic                 done_o
);

`ifdef MEM_RD_LAST_EN
    localparam int FIFO_W = RAM_WIDTH + 1;
`else
    localparam int FIFO_W = RAM_WIDTH;
`endif

    rd_state_t            state_reg;
    logic [RAM_ADDRW-1:0] addr_reg;
    logic [LEN_W-1:0]     rem_reg;
    logic                 cmd_ready_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic                 issue;
    logic                 pop;
    logic [1:0]           fifo_cnt;
    logic [FIFO_W-1:0]    push_data;
    logic [FIFO_W-1:0]    head;

    assign pop   = m_valid_o && m_ready_i;
    // Read data is not valid while the write port is active, so no capture then.
    assign issue = (state_reg == READ) && !wr_busy_i && ((fifo_cnt < 2'd2) || pop);

`ifdef MEM_RD_LAST_EN
    assign push_data = {(rem_reg == LEN_W'(1)), ram_rd_data_i};
    assign m_data_o  = head[RAM_WIDTH-1:0];
    assign m_last_o  = head[RAM_WIDTH];
`else
    assign push_data = ram_rd_data_i;
    assign m_data_o  = head;
`endif

    mem_rd_fifo2 #(.WIDTH(FIFO_W)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (issue),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            rem_reg       <= '0;
            cmd_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_reg      <= cmd_base_i;
                        rem_reg       <= cmd_len_i;
                        cmd_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        if (cmd_len_i == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_reg <= (addr_reg == RAM_ADDRW'(RAM_DEPTH - 1)) ? '0
                                                                            : addr_reg + RAM_ADDRW'(1);
                        rem_reg  <= rem_reg - LEN_W'(1);
                        if (rem_reg == LEN_W'(1)) state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave as soon as the FIFO will be empty so done follows the last pop directly.
                    if ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop)) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg     <= IDLE;
                    done_reg      <= 1'b0;
                    busy_reg      <= 1'b0;
                    cmd_ready_reg <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_reg;
    assign busy_o        = busy_reg;
    assign done_o        = done_reg;
    assign ram_rd_addr_o = addr_reg;
    assign m_valid_o     = (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader: directed table, reset abort and random commands
// against a queue model of the expected word sequence.
module tb_mem_stream_reader;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int LW    = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [LW-1:0] cmd_len;
    logic          wr_busy;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          done;
`ifdef MEM_RD_LAST_EN
    logic          m_last;
`endif

    logic [DW-1:0] mem [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Garbage while the write port is busy, as the real RAM would return.
    assign ram_rd_data = wr_busy ? (32'hBADB_A000 | 32'(ram_rd_addr)) : mem[ram_rd_addr];

    mem_stream_reader dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_base_i    (cmd_base),
        .cmd_len_i     (cmd_len),
        .wr_busy_i     (wr_busy),
        .ram_rd_addr_o (ram_rd_addr),
        .ram_rd_data_i (ram_rd_data),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .m_data_o      (m_data),
        .busy_o        (busy),
`ifdef MEM_RD_LAST_EN
        .m_last_o      (m_last),
`endif
        .done_o        (done)
    );

    typedef struct {
        int base;
        int len;
        int ready_mode;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
        int busy_start;   // -1 random write-busy cycles
        int busy_len;
        int exp_done;     // cycle of done after accept, -1 = not fixed
        bit chk_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, "_m_valid"}, 64'(m_valid), 64'(0));
        check({tag, "_m_data"}, 64'(m_data), 64'(0));
        check({tag, "_addr"}, 64'(ram_rd_addr), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
`ifdef MEM_RD_LAST_EN
        check({tag, "_last"}, 64'(m_last), 64'(0));
`endif
    endtask

    task automatic run_cmd(input vec_t v);
        int            exp_q[$];
        int            k, pops, done_k, last_pop_k, first_v, a;
        bit            prev_stall, prev_busy;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] prev_addr;
        bit            pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < v.len; i++) exp_q.push_back((v.base + i) % DEPTH);
        pops = 0; done_k = -1; last_pop_k = -1; first_v = -1;
        prev_stall = 0; prev_busy = 0; prev_data = '0; prev_addr = '0;

        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base = AW'(v.base); cmd_len = LW'(v.len);
        m_ready = 1'b0; wr_busy = 1'b0;
        @(negedge clk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        @(posedge clk); #1;
        // Keep offering garbage commands; they must be ignored while busy.
        cmd_base = AW'($urandom); cmd_len = LW'($urandom);
        k = 1;
        forever begin
            case (v.ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[(k - 1) % 4];
                default: m_ready = ($urandom_range(0, 9) < 7);
            endcase
            if (v.busy_start < 0) wr_busy = ($urandom_range(0, 4) == 0);
            else wr_busy = (k >= v.busy_start) && (k < v.busy_start + v.busy_len);
            @(negedge clk);
            if (k == 1) check("addr_eq_base", 64'(ram_rd_addr), 64'(v.base));
            if (prev_busy) check("addr_hold_busy", 64'(ram_rd_addr), 64'(prev_addr));
            if (prev_stall) begin
                check("stall_valid", 64'(m_valid), 64'(1));
                check("stall_data", 64'(m_data), 64'(prev_data));
            end
            if (v.len == 0) check("valid_len0", 64'(m_valid), 64'(0));
            if (m_valid && first_v < 0) first_v = k;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(1), 64'(0));
                end else begin
                    a = exp_q.pop_front();
                    check("word", 64'(m_data), 64'(mem[a]));
`ifdef MEM_RD_LAST_EN
                    check("last_flag", 64'(m_last), 64'(exp_q.size() == 0));
`endif
                end
                pops++;
                last_pop_k = k;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_busy  = wr_busy;
            prev_addr  = ram_rd_addr;
            if (done) begin
                done_k = k;
                cmd_valid = 1'b0;
                check("busy_at_done", 64'(busy), 64'(1));
                check("valid_at_done", 64'(m_valid), 64'(0));
                break;
            end
            if (k >= 3000) begin
                check("timeout_waiting_done", 64'(0), 64'(1));
                cmd_valid = 1'b0;
                break;
            end
            @(posedge clk); #1;
            k++;
        end

        check("word_count", 64'(pops), 64'(v.len));
        if (v.chk_lat && v.len > 0) check("first_valid_cycle", 64'(first_v), 64'(2));
        if (v.len > 0 && done_k >= 0) check("done_after_last_pop", 64'(done_k), 64'(last_pop_k + 1));
        if (v.exp_done >= 0) check("done_cycle", 64'(done_k), 64'(v.exp_done));

        @(posedge clk); #1;
        m_ready = 1'b0; wr_busy = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_ready", 64'(cmd_ready), 64'(1));
        check("idle_busy", 64'(busy), 64'(0));
        $display("cmd base=%03h len=%0d ready_mode=%0d words=%0d done_cycle=%0d",
                 v.base, v.len, v.ready_mode, pops, done_k);
    endtask

    vec_t vecs[7];
    vec_t rv;
    logic [31:0] tmp;
    int r;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            tmp = $urandom;
            mem[i] = {tmp[22:0], i[8:0]};
        end
        vecs[0] = '{base: 'h010, len: 4,   ready_mode: 0, busy_start: 0, busy_len: 0, exp_done: 6,   chk_lat: 1};
        vecs[1] = '{base: 'h1FE, len: 4,   ready_mode: 0, busy_start: 0, busy_len: 0, exp_done: 6,   chk_lat: 1};
        vecs[2] = '{base: 'h040, len: 8,   ready_mode: 1, busy_start: 0, busy_len: 0, exp_done: -1,  chk_lat: 1};
        vecs[3] = '{base: 'h080, len: 6,   ready_mode: 0, busy_start: 3, busy_len: 3, exp_done: 11,  chk_lat: 1};
        vecs[4] = '{base: 'h100, len: 0,   ready_mode: 0, busy_start: 0, busy_len: 0, exp_done: 1,   chk_lat: 1};
        vecs[5] = '{base: 'h1F0, len: 512, ready_mode: 0, busy_start: 0, busy_len: 0, exp_done: 514, chk_lat: 1};
        vecs[6] = '{base: 'h005, len: 3,   ready_mode: 1, busy_start: 2, busy_len: 2, exp_done: -1,  chk_lat: 1};

        rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; wr_busy = 1'b0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

        // Reset in the middle of a long read with the FIFO held full.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base = AW'('h030); cmd_len = LW'(16); m_ready = 1'b0;
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midcmd_reset");
        $display("reset asserted during READ base=030 len=16");
        @(posedge clk); #1 rst = 1'b0;
        rv = '{base: 'h020, len: 2, ready_mode: 0, busy_start: 0, busy_len: 0, exp_done: 4, chk_lat: 1};
        run_cmd(rv);

        for (int i = 0; i < 15; i++) begin
            r = $urandom_range(0, 9);
            rv.base       = $urandom_range(0, DEPTH - 1);
            rv.len        = (r == 0) ? 0 : (r == 1) ? $urandom_range(500, 512) : $urandom_range(1, 24);
            rv.ready_mode = 2;
            rv.busy_start = -1;
            rv.busy_len   = 0;
            rv.exp_done   = -1;
            rv.chk_lat    = 0;
            run_cmd(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
